// File: rtl/irq_ctrl_pkg.sv
// Shared register map and bit positions for the device interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [2:0] {
    IRQ_RAW   = 3'd0,
    IRQ_PEND  = 3'd1,
    IRQ_MODE  = 3'd2,
    IRQ_MASK  = 3'd3,
    IRQ_SWSET = 3'd4
  } irq_addr_e;

  localparam int IRQ_DATA_W   = 32;
  // Reserved output bit; the same position is CP0's global-enable bit.
  localparam int IRQ_RSVD_BIT = 31;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
module irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  // NOTE: flops use <= so that s1 and q sample their inputs from the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Device interrupt controller: level/edge capture, SW set, W1C pending and
// per-line masking in front of the CP0 devices_interrupt input.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          irq_i,
  input  logic [2:0]            addr_i,
  input  logic [IRQ_DATA_W-1:0] data_i,
  input  logic                  we_i,
  output logic [IRQ_DATA_W-1:0] data_o,
  output logic [IRQ_DATA_W-1:0] devices_interrupt_o,
  output logic                  irq_any_o
);

  logic [N-1:0] s2, s3;
  logic [N-1:0] p, mode, mask;
  logic [N-1:0] rise, sw_set, pend_clr, eff;
  logic         wr_pend, wr_mode, wr_mask, wr_swset;
  logic         unused_data;

  assign unused_data = ^data_i;

  irq_sync #(.W(N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_i),
    .q   (s2)
  );

  assign wr_pend  = we_i && (addr_i == IRQ_PEND);
  assign wr_mode  = we_i && (addr_i == IRQ_MODE);
  assign wr_mask  = we_i && (addr_i == IRQ_MASK);
  assign wr_swset = we_i && (addr_i == IRQ_SWSET);

  assign rise     = mode & s2 & ~s3;
  assign sw_set   = wr_swset ? data_i[N-1:0] : '0;
  assign pend_clr = wr_pend  ? data_i[N-1:0] : '0;

  // Captures beat a same-cycle software clear so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s3   <= '0;
      p    <= '0;
      mode <= '0;
      mask <= '0;
    end else begin
      s3 <= s2;
      p  <= (p & ~pend_clr) | rise | sw_set;
      if (wr_mode) mode <= data_i[N-1:0];
      if (wr_mask) mask <= data_i[N-1:0];
    end
  end

  // Level lines are pending straight from the synchroniser, never stored.
  assign eff = p | (~mode & s2);

  always_comb begin
    devices_interrupt_o               = '0;
    devices_interrupt_o[N-1:0]        = eff & mask;
    devices_interrupt_o[IRQ_RSVD_BIT] = 1'b0;
  end

  assign irq_any_o = |devices_interrupt_o;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    data_o = '0;
    case (addr_i)
      IRQ_RAW:  data_o[N-1:0] = s2;
      IRQ_PEND: data_o[N-1:0] = eff;
      IRQ_MODE: data_o[N-1:0] = mode;
      IRQ_MASK: data_o[N-1:0] = mask;
      default:  data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic against a
// line-history reference model; a second 8-line instance covers the bounds.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N  = 31;
  localparam int N8 = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  irq = '0;
  logic [2:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic          we = 1'b0;
  logic [31:0]   rdata, dev_int;
  logic          irq_any;

  logic [N8-1:0] irq8 = '0;
  logic [2:0]    addr8 = '0;
  logic [31:0]   wdata8 = '0;
  logic          we8 = 1'b0;
  logic [31:0]   rdata8, dev_int8;
  logic          irq_any8;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: hist[d] is the line sample taken d+1 edges ago.
  logic [N-1:0] p_m, mode_m, mask_m;
  logic [N-1:0] hist [0:2];

  irq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .irq_i(irq), .addr_i(addr), .data_i(wdata),
    .we_i(we), .data_o(rdata), .devices_interrupt_o(dev_int), .irq_any_o(irq_any)
  );

  irq_ctrl #(.N(N8)) dut8 (
    .clk(clk), .rst(rst), .irq_i(irq8), .addr_i(addr8), .data_i(wdata8),
    .we_i(we8), .data_o(rdata8), .devices_interrupt_o(dev_int8), .irq_any_o(irq_any8)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_eff();
    return p_m | (~mode_m & hist[1]);
  endfunction

  function automatic logic [31:0] exp_out();
    logic [31:0] r = '0;
    r[N-1:0] = exp_eff() & mask_m;
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    logic [31:0] r = '0;
    case (a)
      3'd0:    r[N-1:0] = hist[1];
      3'd1:    r[N-1:0] = exp_eff();
      3'd2:    r[N-1:0] = mode_m;
      3'd3:    r[N-1:0] = mask_m;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    logic [N-1:0] rise, sw, clr;
    if (!rst) begin
      p_m = '0; mode_m = '0; mask_m = '0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
    end else begin
      rise = mode_m & hist[1] & ~hist[2];
      sw   = '0;
      clr  = '0;
      if (we) begin
        case (addr)
          3'd1: clr    = wdata[N-1:0];
          3'd2: mode_m = wdata[N-1:0];
          3'd3: mask_m = wdata[N-1:0];
          3'd4: sw     = wdata[N-1:0];
          default: ;
        endcase
      end
      p_m     = (p_m & ~clr) | rise | sw;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = irq;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic do_write8(input logic [2:0] a, input logic [31:0] d);
    addr8 = a; wdata8 = d; we8 = 1'b1;
    step();
    we8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; irq = '1; irq8 = '1;
    step(); step();
    n_checks++; if (dev_int !== 32'h0) $display("FAIL rst_out: got %h want %h", dev_int, 32'h0); else n_pass++;
    n_checks++; if (irq_any !== 1'b0) $display("FAIL rst_any: got %b want 0", irq_any); else n_pass++;
    n_checks++; if (dev_int8 !== 32'h0) $display("FAIL rst_out8: got %h want %h", dev_int8, 32'h0); else n_pass++;
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a); #1;
      n_checks++; if (rdata !== 32'h0) $display("FAIL rst_read[%0d]: got %h want %h", a, rdata, 32'h0); else n_pass++;
    end
    rst = 1'b1;
    addr = IRQ_RAW;
    step(); #1;
    n_checks++; if (rdata !== 32'h0) $display("FAIL raw_after1: got %h want %h", rdata, 32'h0); else n_pass++;
    step(); #1;
    n_checks++; if (rdata !== 32'h7fff_ffff) $display("FAIL raw_after2: got %h want %h", rdata, 32'h7fff_ffff); else n_pass++;
    n_checks++; if (dev_int !== 32'h0) $display("FAIL raw_nomask: got %h want %h", dev_int, 32'h0); else n_pass++;
    irq = '0; irq8 = '0;
    step(); step(); step();
  endtask

  task automatic test_level();
    do_write(IRQ_MASK, 32'h1);
    do_write(IRQ_MODE, 32'h0);
    irq = 31'h1;
    step();
    n_checks++; if (dev_int !== 32'h0) $display("FAIL level_1edge: got %h want %h", dev_int, 32'h0); else n_pass++;
    step();
    n_checks++; if (dev_int !== 32'h1) $display("FAIL level_2edge: got %h want %h", dev_int, 32'h1); else n_pass++;
    n_checks++; if (irq_any !== 1'b1) $display("FAIL level_any: got %b want 1", irq_any); else n_pass++;
    do_write(IRQ_PEND, 32'h1);
    n_checks++; if (dev_int !== 32'h1) $display("FAIL level_w1c: got %h want %h", dev_int, 32'h1); else n_pass++;
    irq = '0;
    step();
    n_checks++; if (dev_int !== 32'h1) $display("FAIL level_drop1: got %h want %h", dev_int, 32'h1); else n_pass++;
    step();
    n_checks++; if (dev_int !== 32'h0) $display("FAIL level_drop2: got %h want %h", dev_int, 32'h0); else n_pass++;
  endtask

  task automatic test_edge();
    do_write(IRQ_MODE, 32'h4);
    do_write(IRQ_MASK, 32'h4);
    irq = 31'h4;
    step(); step();
    n_checks++; if (dev_int !== 32'h0) $display("FAIL edge_2edge: got %h want %h", dev_int, 32'h0); else n_pass++;
    step();
    n_checks++; if (dev_int !== 32'h4) $display("FAIL edge_3edge: got %h want %h", dev_int, 32'h4); else n_pass++;
    irq = '0;
    step(); step(); step();
    n_checks++; if (dev_int !== 32'h4) $display("FAIL edge_sticky: got %h want %h", dev_int, 32'h4); else n_pass++;
    do_write(IRQ_PEND, 32'h4);
    n_checks++; if (dev_int !== 32'h0) $display("FAIL edge_clear: got %h want %h", dev_int, 32'h0); else n_pass++;
    irq = 31'h4;
    step(); step(); step();
    n_checks++; if (dev_int !== 32'h4) $display("FAIL edge_rise2: got %h want %h", dev_int, 32'h4); else n_pass++;
    do_write(IRQ_PEND, 32'h4);
    step(); step(); step(); step();
    n_checks++; if (dev_int !== 32'h0) $display("FAIL edge_held: got %h want %h", dev_int, 32'h0); else n_pass++;
  endtask

  task automatic test_collision();
    irq = '0;
    step(); step(); step();
    irq = 31'h4;
    step(); step();
    do_write(IRQ_PEND, 32'h4);
    n_checks++; if (dev_int !== 32'h4) $display("FAIL coll_out: got %h want %h", dev_int, 32'h4); else n_pass++;
    addr = IRQ_PEND; #1;
    n_checks++; if (rdata !== 32'h4) $display("FAIL coll_pend: got %h want %h", rdata, 32'h4); else n_pass++;
    do_write(IRQ_PEND, 32'h4);
    n_checks++; if (dev_int !== 32'h0) $display("FAIL coll_clear: got %h want %h", dev_int, 32'h0); else n_pass++;
    irq = '0;
    step(); step(); step();
  endtask

  task automatic test_swset_mask();
    do_write(IRQ_MASK, 32'h0);
    do_write(IRQ_SWSET, 32'h4000_0001);
    addr = IRQ_PEND; #1;
    n_checks++; if (rdata !== 32'h4000_0001) $display("FAIL sw_pend: got %h want %h", rdata, 32'h4000_0001); else n_pass++;
    n_checks++; if (dev_int !== 32'h0) $display("FAIL sw_masked: got %h want %h", dev_int, 32'h0); else n_pass++;
    do_write(IRQ_MASK, 32'h7fff_ffff);
    n_checks++; if (dev_int !== 32'h4000_0001) $display("FAIL sw_out: got %h want %h", dev_int, 32'h4000_0001); else n_pass++;
    n_checks++; if (irq_any !== 1'b1) $display("FAIL sw_any: got %b want 1", irq_any); else n_pass++;
    addr = IRQ_SWSET; #1;
    n_checks++; if (rdata !== 32'h0) $display("FAIL sw_read0: got %h want %h", rdata, 32'h0); else n_pass++;
    do_write(IRQ_PEND, 32'hffff_ffff);
    n_checks++; if (dev_int !== 32'h0) $display("FAIL sw_clear: got %h want %h", dev_int, 32'h0); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) irq = N'($urandom);
      we    = ($urandom_range(3) == 0);
      addr  = 3'($urandom_range(7));
      wdata = $urandom;
      #1;
      n_checks++; if (rdata !== exp_read(addr)) $display("FAIL rnd_read[%0d] a=%0d: got %h want %h", i, addr, rdata, exp_read(addr)); else n_pass++;
      step();
      n_checks++; if (dev_int !== exp_out()) $display("FAIL rnd_out[%0d]: got %h want %h", i, dev_int, exp_out()); else n_pass++;
      n_checks++; if (irq_any !== (|exp_out())) $display("FAIL rnd_any[%0d]: got %b want %b", i, irq_any, |exp_out()); else n_pass++;
    end
    we = 1'b0;
  endtask

  task automatic test_midreset();
    do_write(IRQ_MODE, 32'h7fff_ffff);
    do_write(IRQ_MASK, 32'h7fff_ffff);
    do_write(IRQ_SWSET, 32'h1234_5678);
    irq = 31'h3;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    addr = IRQ_PEND; #1;
    n_checks++; if (rdata !== 32'h0) $display("FAIL mid_pend: got %h want %h", rdata, 32'h0); else n_pass++;
    n_checks++; if (dev_int !== 32'h0) $display("FAIL mid_out: got %h want %h", dev_int, 32'h0); else n_pass++;
    addr = IRQ_MODE; #1;
    n_checks++; if (rdata !== 32'h0) $display("FAIL mid_mode: got %h want %h", rdata, 32'h0); else n_pass++;
    irq = '0;
    step(); step(); step();
  endtask

  task automatic test_bounds();
    do_write8(IRQ_MODE, 32'hffff_ffff);
    do_write8(IRQ_MASK, 32'hffff_ffff);
    do_write8(IRQ_SWSET, 32'hffff_ffff);
    addr8 = IRQ_MODE; #1;
    n_checks++; if (rdata8 !== 32'hff) $display("FAIL b_mode: got %h want %h", rdata8, 32'hff); else n_pass++;
    addr8 = IRQ_MASK; #1;
    n_checks++; if (rdata8 !== 32'hff) $display("FAIL b_mask: got %h want %h", rdata8, 32'hff); else n_pass++;
    addr8 = IRQ_PEND; #1;
    n_checks++; if (rdata8 !== 32'hff) $display("FAIL b_pend: got %h want %h", rdata8, 32'hff); else n_pass++;
    addr8 = IRQ_SWSET; #1;
    n_checks++; if (rdata8 !== 32'h0) $display("FAIL b_swset: got %h want %h", rdata8, 32'h0); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      irq8 = 8'($urandom);
      step();
      n_checks++; if (dev_int8 !== 32'hff) $display("FAIL b_out[%0d]: got %h want %h", i, dev_int8, 32'hff); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_collision();
    test_swset_mask();
    test_random();
    test_midreset();
    test_bounds();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
